uart_rx_byte: RTL and testbench



---
 rtl/uart_rx_byte_if.sv | 25 ++
 rtl/uart_rx_byte.sv | 118 +++++++++++
 tb/tb_uart_rx_byte.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_byte_if.sv
// Receiver-side bundle: serial line in, byte strobe / error strobe / busy out.
// master = the receiver, slave = whatever drives the line and consumes the bytes.
interface uart_rx_byte_if;
  logic       uart_rxd;
  logic       rx_en;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       busy;

  modport master (
    input  uart_rxd,
    output rx_en,
    output rx_data,
    output frame_err,
    output busy
  );

  modport slave (
    output uart_rxd,
    input  rx_en,
    input  rx_data,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with mid-bit sampling from an integer divider.
// BAUD_DIV = CLK_FREQ/BAUD_RATE must be at least 4.
module uart_rx_byte #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_byte_if.master bus
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_en_q, rx_en_d;
  logic             frame_err_q, frame_err_d;
  logic             sync1_q, sync2_q, prev_q;
  logic             rxd_s;
  logic             fall;

  assign rxd_s = sync2_q;
  assign fall  = prev_q & ~rxd_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= bus.uart_rxd;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_en_q     <= rx_en_d;
      frame_err_q <= frame_err_d;
    end
  end

  // The counter is cleared on every transition, so each state starts at 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_ONE;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_en_d     = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxd_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rxd_s;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rxd_s) begin
            rx_data_d = shift_q;
            rx_en_d   = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.rx_en     = rx_en_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: frames are pushed as expected events when sent,
// a negedge monitor pops and compares whenever rx_en or frame_err pulses.
module tb_uart_rx_byte;

  localparam int unsigned CLK_FREQ  = 1_000_000;
  localparam int unsigned BAUD_RATE = 100_000;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_byte_if u_if();

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if.master)
  );

  always #5 clk = ~clk;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] prev_data = 8'h00;
  bit         have_prev = 1'b0;
  bit         in_burst = 1'b0;
  int         low_run = 0;
  int         max_low_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Holds the line at the level of frame bit floor(t*10/p10) for clock t, so p10 is
  // the bit period in tenths of a clock (100 = nominal 10 clk/bit).
  task automatic drive_frame(input logic [9:0] bits, input int p10);
    for (int t = 0; t < p10; t++) begin
      @(negedge clk);
      u_if.uart_rxd = bits[(t * 10) / p10];
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int p10);
    exp_t e;
    e.is_err = ~stop;
    e.data   = d;
    sb.push_back(e);
    drive_frame({stop, d, 1'b0}, p10);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      u_if.uart_rxd = 1'b1;
    end
  endtask

  task automatic wait_drained(input string name);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  // Monitor: scoreboard pops, strobe exclusivity, rx_data hold between frames.
  always @(negedge clk) begin
    if (!rst_n) begin
      have_prev = 1'b0;
    end else begin
      if (u_if.rx_en || u_if.frame_err) begin
        check("strobe_exclusive", {31'd0, u_if.rx_en & u_if.frame_err}, 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got rx_en=%0b frame_err=%0b expected none at %0t",
                   u_if.rx_en, u_if.frame_err, $time);
        end else begin
          mon_e = sb.pop_front();
          check("event_kind_frame_err", {31'd0, u_if.frame_err}, {31'd0, mon_e.is_err});
          if (!mon_e.is_err) check("rx_data", {24'd0, u_if.rx_data}, {24'd0, mon_e.data});
        end
      end
      if (have_prev && !u_if.rx_en)
        check("rx_data_hold", {24'd0, u_if.rx_data}, {24'd0, prev_data});
      prev_data = u_if.rx_data;
      have_prev = 1'b1;
      if (in_burst) begin
        if (!u_if.busy) begin
          low_run++;
          if (low_run > max_low_run) max_low_run = low_run;
        end else begin
          low_run = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit         seen_busy;
    logic [7:0] d;
    logic       stop;

    u_if.uart_rxd = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_en",     {31'd0, u_if.rx_en},     0);
    check("reset_rx_data",   {24'd0, u_if.rx_data},   0);
    check("reset_frame_err", {31'd0, u_if.frame_err}, 0);
    check("reset_busy",      {31'd0, u_if.busy},      0);
    rst_n = 1'b1;
    idle(5);

    send_frame(8'h4D, 1'b1, 100);
    check("single_busy_after", {31'd0, u_if.busy}, 0);
    wait_drained("single_drained");
    check("single_rx_data", {24'd0, u_if.rx_data}, 32'h4D);
    idle(10);

    send_frame(8'h4D, 1'b1, 100);
    low_run = 0;
    max_low_run = 0;
    in_burst = 1'b1;
    send_frame(8'h4F, 1'b1, 100);
    send_frame(8'h44, 1'b1, 100);
    send_frame(8'h01, 1'b1, 100);
    send_frame(8'h01, 1'b1, 100);
    in_burst = 1'b0;
    check("b2b_busy_gap_small", {31'd0, max_low_run <= 10}, 1);
    idle(10);
    wait_drained("b2b_drained");
    check("b2b_last_rx_data", {24'd0, u_if.rx_data}, 32'h01);

    seen_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      u_if.uart_rxd = 1'b0;
      seen_busy |= u_if.busy;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      u_if.uart_rxd = 1'b1;
      seen_busy |= u_if.busy;
    end
    check("glitch_busy_seen", {31'd0, seen_busy}, 1);
    check("glitch_busy_cleared", {31'd0, u_if.busy}, 0);
    idle(10);

    send_frame(8'hA5, 1'b0, 100);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      u_if.uart_rxd = 1'b0;
    end
    check("break_busy_low", {31'd0, u_if.busy}, 0);
    idle(20);
    wait_drained("ferr_drained");
    check("ferr_rx_data_kept", {24'd0, u_if.rx_data}, 32'h01);
    send_frame(8'h3C, 1'b1, 100);
    idle(5);
    wait_drained("after_break_drained");
    check("after_break_rx_data", {24'd0, u_if.rx_data}, 32'h3C);

    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, stop, 100);
      idle(stop ? $urandom_range(0, 8) : $urandom_range(2, 10));
    end
    idle(5);
    wait_drained("random_drained");

    idle(10);
    drive_frame(10'b11_1111_1111 & 10'b11_1111_1110, 55);
    check("midframe_busy", {31'd0, u_if.busy}, 1);
    @(negedge clk);
    u_if.uart_rxd = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midreset_rx_en",     {31'd0, u_if.rx_en},     0);
    check("midreset_rx_data",   {24'd0, u_if.rx_data},   0);
    check("midreset_frame_err", {31'd0, u_if.frame_err}, 0);
    check("midreset_busy",      {31'd0, u_if.busy},      0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    send_frame(8'h04, 1'b1, 100);
    idle(5);
    wait_drained("post_reset_drained");
    check("post_reset_rx_data", {24'd0, u_if.rx_data}, 32'h04);

    // Integer 9 or 11 clk/bit drifts a full bit by the stop sample; +/-4% is used instead.
    send_frame(8'h55, 1'b1, 96);
    idle(10);
    wait_drained("fast_baud_drained");
    check("fast_baud_rx_data", {24'd0, u_if.rx_data}, 32'h55);
    send_frame(8'hAA, 1'b1, 100);
    send_frame(8'h55, 1'b1, 104);
    idle(10);
    wait_drained("slow_baud_drained");
    check("slow_baud_rx_data", {24'd0, u_if.rx_data}, 32'h55);

    check("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
